clk_div_n: RTL
==============

# clk_div_n

Parametrised integer clock divider producing `clkout` at f(clk)/N for any runtime-programmable N ≥ 2. Odd divisors give an exact 50 % duty cycle through a negative-edge extension flop. Divisor changes take effect only at an output-period boundary, so no runt pulses occur. It replaces the fixed divide-by-3 blocks in the clock-divider library and feeds downstream logic with a divided clock plus a period-aligned strobe.

## Interface
- `WIDTH`, default 8: width of the divisor and of the internal counter; maximum divisor is 2^WIDTH−1.
- `DIV_DEFAULT`, default 3: divisor active out of reset; must be in the range 2 … 2^WIDTH−1.
- `clk`  in  1: input clock; all state is on the rising edge except the negative-edge extension flop.
- `rst`  in  1: asynchronous, active-low reset.
- `div_in`  in  WIDTH: requested divisor.
- `div_load`  in  1: single-cycle strobe that captures `div_in` as the pending divisor.
- `clkout`  out  1: divided clock.
- `tick`  out  1: one-`clk` pulse during the last input cycle of each output period.
- `div_err`  out  1: sticky flag; set when an illegal divisor (0 or 1) is loaded; cleared only by reset.
- `div_cur`  out  WIDTH: divisor currently in effect.

## Operation
- State:
  - `cnt` counts 0 … N−1 and wraps to 0.
  - `div_q` holds the active N.
  - `pend_q` / `pend_v` hold a pending divisor and its valid bit.
  - `pos_q` is the rising-edge phase flop; `neg_q` is the falling-edge flop.
- Phase: H = N>>1.
  - `pos_q` is registered as (cnt_next < H).
  - Even N: `clkout` = `pos_q`, so it is high for N/2 cycles.
  - Odd N with the feature enabled: `neg_q` samples `pos_q` on the falling edge, and `clkout` = `pos_q` | `neg_q`. Output is high for (N−1)/2 + ½ = N/2 cycles, and rising edges stay on posedge `clk`.
- Divisor load:
  - On `div_load`, `pend_q` ← `div_in` and `pend_v` ← 1. If several loads occur within one period, the last one wins.
  - At the wrap (cnt == N−1), if `pend_v` is set: `div_q` ← `pend_q` and `pend_v` ← 0. The new N governs the period that starts at that wrap.
  - A `div_load` coinciding with the wrap cycle is pending for the following boundary. It is not applied immediately.
  - If `div_in` < 2, the value is clamped to 2 and `div_err` is set in the capture cycle.
- `tick` is registered: it is high exactly while cnt == N−1 and is asserted once per output period.
- Reset (`rst` low, at any time, including mid-period):
  - `cnt` = 0, `div_q` = `DIV_DEFAULT`, `pend_v` = 0.
  - `pos_q` = 0, `neg_q` = 0, so `clkout` = 0.
  - `tick` = 0, `div_err` = 0, `div_cur` = `DIV_DEFAULT`.

## Timing
- First posedge after `rst` rises: cnt = 0 and `pos_q` rises, so `clkout` rises on that edge with zero additional latency.
- Output period is exactly N `clk` cycles, with no gap or extra cycle across a divisor change.
- `div_load` → `div_cur` update: from 1 to N_old cycles, always landing on the boundary posedge.
- `neg_q` sees only `pos_q` and has no combinational path from inputs. For even N, `neg_q` is held at 0.

## Configuration
- `CLK_DIV_HALF_DUTY_EN` defined: the negative-edge flop is present and odd N gives 50 % duty.
- Undefined: there is no falling-edge logic and `clkout` = `pos_q`. Odd N is then high for (N−1)/2 cycles, so divide-by-3 is high 1 of 3. Even-N behaviour is identical in both builds.

## Structure
- Package `clk_div_pkg`:
  - `DIV_MIN` = 2.
  - Default `WIDTH`.
  - A function `clamp_div` for the illegal-value clamp.
- Sub-module `clk_div_negext`: the falling-edge flop with asynchronous active-low reset, instantiated only under `CLK_DIV_HALF_DUTY_EN`. This keeps the mixed-edge logic isolated for timing and lint.

## Test plan
- Reset then free-run with default N = 3, feature on → period 3 `clk`, high 1.5 `clk`; `tick` every 3rd cycle; `div_cur` = 3.
- Load 4 at cnt = 1 → current 3-cycle period completes; subsequent periods are 4 cycles, high 2; `div_cur` becomes 4 exactly at the wrap.
- Load 1, then 0 → `div_cur` = 2 after the boundary; `div_err` = 1 and stays set.
- WIDTH = 8, load 255 → period 255, high 127.5 with feature on (127 with feature off).
- Loads of 5 then 7 within one period → only 7 is applied; a load on the wrap cycle is applied at the next boundary.
- `rst` low mid-period at N = 7 → `clkout`, `tick` and `cnt` are immediately 0; after release, the period restarts with N = `DIV_DEFAULT`.

Source files
------------

// File: rtl/clk_div_pkg.sv
// ============================================================
// clk_div_pkg : shared constants and divisor clamp helper
// Rev 1.0
// ============================================================
`default_nettype none

package clk_div_pkg;

  localparam int DIV_MIN       = 2;
  localparam int WIDTH_DEFAULT = 8;

  // Divisors of 0 or 1 cannot form a period; clamp them to the minimum.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_negext.sv
// ============================================================
// clk_div_negext : falling-edge extension flop for odd divisors
// Rev 1.0
// ============================================================
`default_nettype none

module clk_div_negext (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/clk_div_n.sv
// ============================================================
// clk_div_n : runtime-programmable integer clock divider, N >= 2
// Option CLK_DIV_HALF_DUTY_EN: 50% duty for odd N.  Rev 1.0
// ============================================================
`default_nettype none

module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int DIV_DEFAULT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clkout,
  output logic             tick,
  output logic             div_err,
  output logic [WIDTH-1:0] div_cur
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] pend_q;
  logic             pend_v;
  logic             run;
  logic             pos_q;

  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] div_next;
  logic [WIDTH-1:0] load_val;
  logic             load_bad;
  logic             wrap;

  // The first edge after reset opens period 0 instead of advancing cnt,
  // so clkout rises on that very edge.
  always_comb begin
    wrap     = run && (cnt == div_q - ONE);
    div_next = (wrap && pend_v) ? pend_q : div_q;
    cnt_next = (!run || wrap) ? '0 : cnt + ONE;
    load_val = WIDTH'(clamp_div(32'(div_in)));
    load_bad = 32'(div_in) < 32'(DIV_MIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run     <= 1'b0;
      cnt     <= '0;
      div_q   <= DIV_RST;
      pend_q  <= DIV_RST;
      pend_v  <= 1'b0;
      pos_q   <= 1'b0;
      tick    <= 1'b0;
      div_err <= 1'b0;
    end else begin
      run   <= 1'b1;
      cnt   <= cnt_next;
      div_q <= div_next;
      pos_q <= cnt_next < (div_next >> 1);
      tick  <= cnt_next == (div_next - ONE);
      // A load on the wrap cycle stays pending for the next boundary.
      if (div_load) begin
        pend_q <= load_val;
        pend_v <= 1'b1;
        if (load_bad) div_err <= 1'b1;
      end else if (wrap) begin
        pend_v <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_HALF_DUTY_EN
  logic neg_q;

  // Gated by div_q[0] so even divisors keep the extension flop at 0.
  clk_div_negext u_negext (
    .clk   (clk),
    .rst_n (rst),
    .d     (pos_q & div_q[0]),
    .q     (neg_q)
  );

  assign clkout = pos_q | neg_q;
`else
  assign clkout = pos_q;
`endif

  assign div_cur = div_q;

endmodule

`default_nettype wire
